// File: rtl/johnson_pkg.sv
// Shared constants, state encoding and Johnson-code helpers for the
// Johnson/Gray sequencer slice.
package johnson_pkg;

  localparam int JOHNSON_W = 4;
  localparam int GRAY_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RECOVER
  } seq_state_t;

  function automatic logic is_legal_johnson(input logic [JOHNSON_W-1:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0011, 4'b0111,
      4'b1111, 4'b1110, 4'b1100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Illegal codes report phase 0; they never live in the register for long.
  function automatic logic [2:0] johnson_idx(input logic [JOHNSON_W-1:0] code);
    case (code)
      4'b0000: return 3'd0;
      4'b0001: return 3'd1;
      4'b0011: return 3'd2;
      4'b0111: return 3'd3;
      4'b1111: return 3'd4;
      4'b1110: return 3'd5;
      4'b1100: return 3'd6;
      4'b1000: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/johnson_to_gray.sv
// 4-bit Johnson to 3-bit Gray converter: g2 = j3, g1 = j1, g0 = j0 ^ j2,
// built in the selected gate basis (AND/OR/NOT, NOR-only or NAND-only).
module johnson_to_gray
  import johnson_pkg::*;
#(
  parameter string REALIZATION = "MDNF"
) (
  input  logic [JOHNSON_W-1:0] j,
  output logic [GRAY_W-1:0]    g
);

  if (REALIZATION == "PIRS") begin : g_pirs
    logic nj0, nj1, nj2, nj3, n1, n2, nx;
    assign nj0  = ~(j[0] | j[0]);
    assign nj1  = ~(j[1] | j[1]);
    assign nj2  = ~(j[2] | j[2]);
    assign nj3  = ~(j[3] | j[3]);
    assign n1   = ~(j[0] | nj2);
    assign n2   = ~(nj0 | j[2]);
    assign nx   = ~(n1 | n2);
    assign g[0] = ~(nx | nx);
    assign g[1] = ~(nj1 | nj1);
    assign g[2] = ~(nj3 | nj3);
  end else if (REALIZATION == "SHEFFER") begin : g_sheffer
    logic m, a, b, nj1, nj3;
    assign m    = ~(j[0] & j[2]);
    assign a    = ~(j[0] & m);
    assign b    = ~(j[2] & m);
    assign g[0] = ~(a & b);
    assign nj1  = ~(j[1] & j[1]);
    assign nj3  = ~(j[3] & j[3]);
    assign g[1] = ~(nj1 & nj1);
    assign g[2] = ~(nj3 & nj3);
  end else begin : g_mdnf
    assign g[0] = (j[0] & ~j[2]) | (~j[0] & j[2]);
    assign g[1] = j[1];
    assign g[2] = j[3];
  end

endmodule

// File: rtl/johnson_gray_sequencer.sv
// Johnson counter sequencer with start/stop, direction, prescaled stepping,
// synchronous loads and recovery from illegal load codes.
module johnson_gray_sequencer
  import johnson_pkg::*;
#(
  parameter string REALIZATION = "MDNF",
  parameter int    STEP_DIV    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 dir,
  input  logic                 load,
  input  logic [JOHNSON_W-1:0] load_val,
  output logic [JOHNSON_W-1:0] j,
  output logic [GRAY_W-1:0]    g,
  output logic [2:0]           idx,
  output logic                 running,
  output logic                 wrap,
  output logic                 err
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

  seq_state_t state, state_nxt;
  seq_state_t ret_state, ret_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [JOHNSON_W-1:0] j_nxt;
  logic wrap_nxt;
  logic step_due;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ret_state <= IDLE;
      presc     <= '0;
      j         <= '0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      presc     <= presc_nxt;
      j         <= j_nxt;
      wrap      <= wrap_nxt;
    end
  end

  // Stop/start still act alongside a load; the load only pre-empts the step.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    presc_nxt = presc;
    j_nxt     = j;
    wrap_nxt  = 1'b0;
    step_due  = 1'b0;
    err       = 1'b0;

    case (state)
      IDLE: begin
        presc_nxt = '0;
        if (start && !stop) state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          presc_nxt = '0;
        end else if (presc == PRESC_LAST) begin
          presc_nxt = '0;
          step_due  = 1'b1;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      RECOVER: begin
        j_nxt     = '0;
        presc_nxt = '0;
        state_nxt = ret_state;
      end
      default: state_nxt = IDLE;
    endcase

    if (step_due) begin
      if (dir) begin
        j_nxt    = {~j[0], j[3:1]};
        wrap_nxt = (j == 4'b0000);
      end else begin
        j_nxt    = {j[2:0], ~j[3]};
        wrap_nxt = (j == 4'b1000);
      end
    end

    // An illegal load parks the register at 0000 for one RECOVER cycle and
    // remembers where to go afterwards.
    if (load) begin
      wrap_nxt  = 1'b0;
      presc_nxt = '0;
      if (is_legal_johnson(load_val)) begin
        j_nxt = load_val;
      end else begin
        err       = !rst;
        j_nxt     = '0;
        ret_nxt   = state_nxt;
        state_nxt = RECOVER;
      end
    end
  end

  assign running = (state == RUN);
  assign idx     = johnson_idx(j);

  johnson_to_gray #(
    .REALIZATION(REALIZATION)
  ) u_j2g (
    .j(j),
    .g(g)
  );

endmodule

// File: tb/tb_johnson_gray_sequencer.sv
// Directed bench for johnson_gray_sequencer: three realizations share one
// stimulus stream at STEP_DIV=1, a fourth instance exercises STEP_DIV=3.
module tb_johnson_gray_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop, dir, load;
  logic [3:0] load_val;
  logic [3:0] j_m, j_p, j_s;
  logic [2:0] g_m, g_p, g_s, idx_m, idx_p, idx_s;
  logic       run_m, run_p, run_s, wrap_m, wrap_p, wrap_s, err_m, err_p, err_s;

  logic       rst3, start3, stop3, dir3, load3;
  logic [3:0] load_val3;
  logic [3:0] j_3;
  logic [2:0] g_3, idx_3;
  logic       run_3, wrap_3, err_3;

  int compared   = 0;
  int mismatched = 0;

  johnson_gray_sequencer #(.REALIZATION("MDNF"), .STEP_DIV(1)) dut_m (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .j(j_m), .g(g_m), .idx(idx_m), .running(run_m),
    .wrap(wrap_m), .err(err_m));

  johnson_gray_sequencer #(.REALIZATION("PIRS"), .STEP_DIV(1)) dut_p (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .j(j_p), .g(g_p), .idx(idx_p), .running(run_p),
    .wrap(wrap_p), .err(err_p));

  johnson_gray_sequencer #(.REALIZATION("SHEFFER"), .STEP_DIV(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .j(j_s), .g(g_s), .idx(idx_s), .running(run_s),
    .wrap(wrap_s), .err(err_s));

  johnson_gray_sequencer #(.REALIZATION("MDNF"), .STEP_DIV(3)) dut_3 (
    .clk(clk), .rst(rst3), .start(start3), .stop(stop3), .dir(dir3), .load(load3),
    .load_val(load_val3), .j(j_3), .g(g_3), .idx(idx_3), .running(run_3),
    .wrap(wrap_3), .err(err_3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  // Checks the three STEP_DIV=1 instances against one expected picture.
  task automatic check_output(input string tag, input logic [3:0] ej, input logic [2:0] eg,
                              input logic [2:0] eidx, input logic erun, input logic ewrap);
    check({tag, ".j"},       j_m,           ej);
    check({tag, ".g"},       {1'b0, g_m},   {1'b0, eg});
    check({tag, ".idx"},     {1'b0, idx_m}, {1'b0, eidx});
    check({tag, ".running"}, {3'b0, run_m}, {3'b0, erun});
    check({tag, ".wrap"},    {3'b0, wrap_m}, {3'b0, ewrap});
    check({tag, ".pirs.j"},  j_p,           ej);
    check({tag, ".pirs.g"},  {1'b0, g_p},   {1'b0, eg});
    check({tag, ".shef.j"},  j_s,           ej);
    check({tag, ".shef.g"},  {1'b0, g_s},   {1'b0, eg});
  endtask

  task automatic check_div3(input string tag, input logic [3:0] ej, input logic erun);
    check({tag, ".j"},       j_3,           ej);
    check({tag, ".running"}, {3'b0, run_3}, {3'b0, erun});
  endtask

  logic [3:0] fwd_j   [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                              4'b1100, 4'b1000, 4'b0000, 4'b0001};
  logic [2:0] fwd_g   [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                              3'b101, 3'b100, 3'b000, 3'b001};
  logic [2:0] fwd_idx [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0000;
    rst3 = 1'b1; start3 = 1'b0; stop3 = 1'b0; dir3 = 1'b0; load3 = 1'b0; load_val3 = 4'b0000;
    tick();
    tick();
    check_output("reset", 4'b0000, 3'b000, 3'd0, 1'b0, 1'b0);
    check("reset.err", {3'b0, err_m}, 4'b0000);

    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("start", 4'b0000, 3'b000, 3'd0, 1'b1, 1'b0);

    for (int i = 0; i < 9; i++) begin
      tick();
      check_output($sformatf("fwd%0d", i), fwd_j[i], fwd_g[i], fwd_idx[i], 1'b1, (i == 7));
    end

    tick();
    check_output("to0011", 4'b0011, 3'b011, 3'd2, 1'b1, 1'b0);
    dir = 1'b1;
    tick();
    check_output("rev0", 4'b0001, 3'b001, 3'd1, 1'b1, 1'b0);
    tick();
    check_output("rev1", 4'b0000, 3'b000, 3'd0, 1'b1, 1'b0);
    tick();
    check_output("rev_wrap", 4'b1000, 3'b100, 3'd7, 1'b1, 1'b1);
    dir = 1'b0;
    tick();
    check_output("dir_back", 4'b0000, 3'b000, 3'd0, 1'b1, 1'b1);

    load = 1'b1; load_val = 4'b1110;
    #1;
    check("legal.err", {3'b0, err_m}, 4'b0000);
    tick();
    load = 1'b0;
    check_output("legal_load", 4'b1110, 3'b111, 3'd5, 1'b1, 1'b0);
    tick();
    check_output("after_load", 4'b1100, 3'b101, 3'd6, 1'b1, 1'b0);

    load = 1'b1; load_val = 4'b0101;
    #1;
    check("illegal.err", {3'b0, err_m}, 4'b0001);
    check("illegal.err_pirs", {3'b0, err_p}, 4'b0001);
    tick();
    load = 1'b0;
    #1;
    check("illegal.err_drop", {3'b0, err_m}, 4'b0000);
    check_output("recover", 4'b0000, 3'b000, 3'd0, 1'b0, 1'b0);
    tick();
    check_output("resume", 4'b0000, 3'b000, 3'd0, 1'b1, 1'b0);
    tick();
    check_output("resume_step", 4'b0001, 3'b001, 3'd1, 1'b1, 1'b0);

    load = 1'b1; load_val = 4'b0111; stop = 1'b1;
    tick();
    load = 1'b0; stop = 1'b0;
    check_output("load_stop", 4'b0111, 3'b010, 3'd3, 1'b0, 1'b0);
    tick();
    check_output("idle_hold", 4'b0111, 3'b010, 3'd3, 1'b0, 1'b0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_output("start_stop", 4'b0111, 3'b010, 3'd3, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("restart", 4'b0111, 3'b010, 3'd3, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mid_reset", 4'b0000, 3'b000, 3'd0, 1'b0, 1'b0);

    rst3 = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check_div3("d3_start", 4'b0000, 1'b1);
    tick();
    check_div3("d3_e1", 4'b0000, 1'b1);
    tick();
    check_div3("d3_e2", 4'b0000, 1'b1);
    tick();
    check_div3("d3_e3", 4'b0001, 1'b1);
    tick();
    tick();
    check_div3("d3_e5", 4'b0001, 1'b1);
    tick();
    check_div3("d3_e6", 4'b0011, 1'b1);
    tick();
    tick();
    stop3 = 1'b1;
    tick();
    stop3 = 1'b0;
    check_div3("d3_stop", 4'b0011, 1'b0);
    tick();
    check_div3("d3_frozen", 4'b0011, 1'b0);

    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    load3 = 1'b1; load_val3 = 4'b1110;
    tick();
    load3 = 1'b0;
    check_div3("d3_load", 4'b1110, 1'b1);
    check("d3_load.g", {1'b0, g_3}, 4'b0111);
    tick();
    tick();
    check_div3("d3_load_hold", 4'b1110, 1'b1);
    tick();
    check_div3("d3_load_step", 4'b1100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/johnson_gray_sequencer.md
# johnson_gray_sequencer

Sequencer for the 4-bit Johnson-to-Gray datapath. It owns a 4-bit Johnson counter register and steps it forward or backward under start/stop/enable control, with a programmable step rate. It accepts synchronous loads and recovers automatically from illegal Johnson codes. The 3-bit Gray output is produced by an internal `johnson_to_gray` instance. The block sits between control logic and any consumer of the Gray/Johnson phase sequence.

## Interface
- `REALIZATION`, default "MDNF": forwarded to the `johnson_to_gray` instance. Legal values: "MDNF", "PIRS", "SHEFFER".
- `STEP_DIV`, default 1: number of clock cycles per step while running. Range 1..256.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  IDLE→RUN request.
- `stop`  in  1  RUN→IDLE request.
- `dir`  in  1  0 = forward, 1 = reverse; sampled on each step.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  4  Johnson code to load.
- `j`  out  4  current Johnson register.
- `g`  out  3  Gray code of `j`, combinational through `johnson_to_gray`.
- `idx`  out  3  phase index 0..7 of `j`.
- `running`  out  1  high in RUN.
- `wrap`  out  1  one-cycle pulse on the 1000→0000 (fwd) or 0000→1000 (rev) step.
- `err`  out  1  one-cycle pulse when an illegal `load_val` is seen.

## Operation
- **Legal codes and phase index:** 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 map to `idx` 0..7. Matching `g`: 000, 001, 011, 010, 110, 111, 101, 100.
- **Forward step:** `j` <= {j[2:0], ~j[3]}.
- **Reverse step:** `j` <= {~j[0], j[3:1]}.
- **States:**
  - IDLE: `j` held, prescaler cleared.
    - `start` → RUN.
  - RUN: step when the prescaler reaches STEP_DIV-1; the prescaler then wraps to 0.
    - `stop` → IDLE. No step is taken on the `stop` cycle.
  - RECOVER: one cycle. `j` is forced to 0000, the prescaler is cleared, then the block returns to the state held before the load.
- **Priority, highest first:** `rst`, `load`, `stop`, `start`, step.
- **Load:**
  - Legal `load_val`: `j` <= `load_val` next cycle, prescaler <= 0, state unchanged.
  - Illegal `load_val`: `err` pulses the same cycle; next cycle `j` <= 0000 and the block enters RECOVER.
- **Simultaneous requests:**
  - `start` and `stop` together in IDLE: stay in IDLE.
  - `load` during RUN: no step that cycle.
- **Direction change:** a change of `dir` mid-run takes effect on the next step and needs no re-sync.
- **Idle start/stop:** `start` in RUN and `stop` in IDLE are ignored.

## Timing
- **Reset values:** `j`=0000, `g`=000, `idx`=0, `running`=0, `wrap`=0, `err`=0, state IDLE, prescaler 0.
- **Reset mid-operation:** restores all reset values on the next edge. A pending load or step is discarded.
- **First step after start:** STEP_DIV cycles after the `start` edge. With STEP_DIV=1, `j` advances on every edge from the cycle after RUN is entered.
- **Output latency:** `g` and `idx` follow `j` in the same cycle (combinational, 0 latency). `wrap` is registered and coincides with the new `j`.
- **Full cycle:** 8 steps return to the starting code, i.e. 8×STEP_DIV cycles.

## Structure
- **Package `johnson_pkg`:**
  - constants: JOHNSON_W=4, GRAY_W=3;
  - state enum {IDLE, RUN, RECOVER};
  - function `is_legal_johnson(4b)→1b`;
  - function `johnson_idx(4b)→3b`.
- **Sub-module:** one instance of the existing `johnson_to_gray`, parameterised by REALIZATION. The sequencer contains no other Gray logic.

## Test plan
- **Reset and free-run:** reset, `start`, STEP_DIV=1, `dir`=0, 9 cycles → `j` sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001. `g` sequence 001, 011, 010, 110, 111, 101, 100, 000, 001. `wrap` pulses once at 0000.
- **Reverse and direction change:** from `j`=0011 with `dir`=1 → 0001, 0000, 1000, with `wrap` at 1000. Then `dir`=0 → 0000.
- **Step divider:** STEP_DIV=3, `start` → `j` changes only every 3rd cycle. `stop` asserted one cycle before a step → `j` frozen, `running`=0.
- **Load:**
  - legal `load_val`=1110 in RUN → `j`=1110, `g`=111, the next step comes STEP_DIV cycles later;
  - illegal `load_val`=0101 → `err`=1 for one cycle, `j`=0000, RUN resumes after RECOVER.
- **Simultaneous events and reset:**
  - `start`+`stop` in IDLE → stays IDLE;
  - `load`+`stop` in RUN → load applied and IDLE entered;
  - `rst` mid-run at `j`=0111 → all outputs at reset values next cycle.
- **Realizations:** repeat the free-run scenario for REALIZATION "PIRS" and "SHEFFER" → identical `g` sequence.
